acc_core: RTL and testbench

Parametrised accumulator CPU core, the next generation of the 4-bit computer datapath. It is generalised in data width, program-counter width and RAM depth, and replaces the free-running PC/ROM wiring with an explicit FETCH/DECODE/EXEC state machine. It adds run/halt control, a zero flag, conditional branches and a retire strobe. Program memory is external with synchronous read; the data RAM is internal.

---
 rtl/acc_core_pkg.sv | 53 +++++
 rtl/acc_core_ram.sv | 27 ++
 rtl/acc_core.sv | 187 ++++++++++++++++++
 tb/tb_acc_core.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_core_pkg.sv
// Shared opcode/state encodings for the acc_core accumulator CPU.
// Optional carry support is selected with ACC_CORE_CARRY_EN (see acc_core.sv).
package acc_core_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LDM  = 4'h2,
        OP_STM  = 4'h3,
        OP_ADDI = 4'h4,
        OP_ADDM = 4'h5,
        OP_SUBI = 4'h6,
        OP_SUBM = 4'h7,
        OP_ANDM = 4'h8,
        OP_ORM  = 4'h9,
        OP_XORM = 4'hA,
        OP_JMP  = 4'hB,
        OP_JZ   = 4'hC,
        OP_JC   = 4'hD,
        OP_ADCM = 4'hE,
        OP_HLT  = 4'hF
    } opcode_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Opcode constants for assembler-side ROM images
    localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_LDI  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_LDM  = 4'h2;
    localparam logic [OPC_W-1:0] OPC_STM  = 4'h3;
    localparam logic [OPC_W-1:0] OPC_ADDI = 4'h4;
    localparam logic [OPC_W-1:0] OPC_ADDM = 4'h5;
    localparam logic [OPC_W-1:0] OPC_SUBI = 4'h6;
    localparam logic [OPC_W-1:0] OPC_SUBM = 4'h7;
    localparam logic [OPC_W-1:0] OPC_ANDM = 4'h8;
    localparam logic [OPC_W-1:0] OPC_ORM  = 4'h9;
    localparam logic [OPC_W-1:0] OPC_XORM = 4'hA;
    localparam logic [OPC_W-1:0] OPC_JMP  = 4'hB;
    localparam logic [OPC_W-1:0] OPC_JZ   = 4'hC;
    localparam logic [OPC_W-1:0] OPC_JC   = 4'hD;
    localparam logic [OPC_W-1:0] OPC_ADCM = 4'hE;
    localparam logic [OPC_W-1:0] OPC_HLT  = 4'hF;

endpackage

// File: rtl/acc_core_ram.sv
// Data RAM for acc_core: combinational read, synchronous write, no reset.
module acc_core_ram
    import acc_core_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RAM_AW = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** RAM_AW;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/acc_core.sv
// Parametrised accumulator CPU core with FETCH/DECODE/EXEC sequencing.
// Define ACC_CORE_CARRY_EN to add the carry flag, JC and ADCM.
module acc_core
    import acc_core_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned PC_W   = 4,
    parameter int unsigned RAM_AW = 4,
    parameter int unsigned OPND_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    output logic [PC_W-1:0]         imem_addr,
    input  logic [OPC_W+OPND_W-1:0] imem_data,
    output logic [DATA_W-1:0]       acc,
    output logic [PC_W-1:0]         pc,
    output logic [STATE_W-1:0]      state,
    output logic                    zero,
    output logic                    carry,
    output logic                    busy,
    output logic                    halted,
    output logic                    retire
);

`ifdef ACC_CORE_CARRY_EN
    localparam int unsigned SUM_W = DATA_W + 1;
`else
    localparam int unsigned SUM_W = DATA_W;
`endif

    if (OPND_W < DATA_W || OPND_W < PC_W || OPND_W < RAM_AW) begin : g_opnd_chk
        $error("acc_core: OPND_W must be >= max(DATA_W, PC_W, RAM_AW)");
    end

    state_t                    state_q, state_nx;
    logic [PC_W-1:0]           pc_nx, addr_nx, target;
    logic [OPC_W+OPND_W-1:0]   ir, ir_nx;
    logic [DATA_W-1:0]         acc_nx, imm, ram_rdata, alu_b;
    logic [RAM_AW-1:0]         ram_addr;
    logic [SUM_W-1:0]          sum;
    logic                      zero_nx, acc_wr, ram_we;
    opcode_t                   opc;

    // Operand fields are always taken from the low bits of the operand
    assign opc      = opcode_t'(ir[OPND_W +: OPC_W]);
    assign imm      = ir[DATA_W-1:0];
    assign ram_addr = ir[RAM_AW-1:0];
    assign target   = ir[PC_W-1:0];
    assign alu_b    = (opc == OP_ADDI || opc == OP_SUBI) ? imm : ram_rdata;
    assign ram_we   = (state_q == ST_EXEC) && (opc == OP_STM) && !rst;
    assign state    = state_q;

`ifdef ACC_CORE_CARRY_EN
    logic carry_q, carry_nx;
    assign carry = carry_q;
`else
    assign carry = 1'b0;
`endif

    acc_core_ram #(
        .DATA_W (DATA_W),
        .RAM_AW (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (acc),
        .rdata (ram_rdata)
    );

    // Next-state, ALU and program-counter logic
    always_comb begin
        state_nx = state_q;
        pc_nx    = pc;
        addr_nx  = imem_addr;
        ir_nx    = ir;
        acc_nx   = acc;
        zero_nx  = zero;
        acc_wr   = 1'b0;
        sum      = '0;
`ifdef ACC_CORE_CARRY_EN
        carry_nx = carry_q;
`endif
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (run) begin
                    state_nx = ST_FETCH;
                    pc_nx    = '0;
                    addr_nx  = '0;
                end
            end
            ST_FETCH: begin
                addr_nx  = pc;
                state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                ir_nx    = imem_data;
                state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                state_nx = ST_FETCH;
                pc_nx    = pc + PC_W'(1);
                case (opc)
                    OP_LDI, OP_LDM: begin
                        acc_nx = alu_b;
                        acc_wr = 1'b1;
                        if (opc == OP_LDI) acc_nx = imm;
                    end
                    OP_ADDI, OP_ADDM: begin
                        sum    = SUM_W'(acc) + SUM_W'(alu_b);
                        acc_nx = sum[DATA_W-1:0];
                        acc_wr = 1'b1;
`ifdef ACC_CORE_CARRY_EN
                        carry_nx = sum[DATA_W];
`endif
                    end
                    OP_SUBI, OP_SUBM: begin
                        sum    = SUM_W'(acc) + SUM_W'(~alu_b) + SUM_W'(1);
                        acc_nx = sum[DATA_W-1:0];
                        acc_wr = 1'b1;
`ifdef ACC_CORE_CARRY_EN
                        carry_nx = sum[DATA_W];
`endif
                    end
                    OP_ANDM: begin acc_nx = acc & ram_rdata; acc_wr = 1'b1; end
                    OP_ORM:  begin acc_nx = acc | ram_rdata; acc_wr = 1'b1; end
                    OP_XORM: begin acc_nx = acc ^ ram_rdata; acc_wr = 1'b1; end
                    OP_JMP:  pc_nx = target;
                    OP_JZ:   if (zero) pc_nx = target;
`ifdef ACC_CORE_CARRY_EN
                    OP_JC:   if (carry_q) pc_nx = target;
                    OP_ADCM: begin
                        sum      = SUM_W'(acc) + SUM_W'(ram_rdata) + SUM_W'(carry_q);
                        acc_nx   = sum[DATA_W-1:0];
                        acc_wr   = 1'b1;
                        carry_nx = sum[DATA_W];
                    end
`endif
                    OP_HLT: begin
                        state_nx = ST_HALT;
                        pc_nx    = pc;
                    end
                    default: ;
                endcase
                // Pre-point the synchronous ROM at the next fetch address
                addr_nx = pc_nx;
                if (acc_wr) zero_nx = (acc_nx == '0);
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc        <= '0;
            imem_addr <= '0;
            ir        <= '0;
            acc       <= '0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            retire    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            pc        <= pc_nx;
            imem_addr <= addr_nx;
            ir        <= ir_nx;
            acc       <= acc_nx;
            zero      <= zero_nx;
            busy      <= (state_nx == ST_FETCH) || (state_nx == ST_DECODE) ||
                         (state_nx == ST_EXEC);
            halted    <= (state_nx == ST_HALT);
            retire    <= (state_nx == ST_EXEC);
        end
    end

`ifdef ACC_CORE_CARRY_EN
    always_ff @(posedge clk) begin
        if (rst) carry_q <= 1'b0;
        else     carry_q <= carry_nx;
    end
`endif

endmodule

// File: tb/tb_acc_core.sv
// Directed self-checking bench for acc_core with a synchronous-read program ROM.
module tb_acc_core;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned PC_W   = 4;
    localparam int unsigned RAM_AW = 4;
    localparam int unsigned OPND_W = 4;

`ifdef ACC_CORE_CARRY_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [PC_W-1:0]   imem_addr;
    logic [OPND_W+3:0] imem_data;
    logic [DATA_W-1:0] acc;
    logic [PC_W-1:0]   pc;
    logic [2:0]        state;
    logic              zero, carry, busy, halted, retire;

    logic [7:0] rom [16];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= rom[imem_addr];

    acc_core #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .RAM_AW (RAM_AW),
        .OPND_W (OPND_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .acc       (acc),
        .pc        (pc),
        .state     (state),
        .zero      (zero),
        .carry     (carry),
        .busy      (busy),
        .halted    (halted),
        .retire    (retire)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    // Start from IDLE/HALT: busy and first fetch address on the next cycle
    task automatic start(input string tag);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " fetch"}, 32'(state), 32'd1);
        chk({tag, " addr0"}, 32'(imem_addr), 32'd0);
    endtask

    // One instruction from FETCH: DECODE, EXEC (retire), then back out
    task automatic exec_one(input string tag);
        tick();
        chk({tag, " decode"}, 32'(state), 32'd2);
        tick();
        chk({tag, " retire"}, 32'(retire), 32'd1);
        tick();
        chk({tag, " retire low"}, 32'(retire), 32'd0);
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        while (state != 3'd4 && n < 20) begin
            exec_one(tag);
            n++;
        end
        chk({tag, " halted"}, 32'(halted), 32'd1);
        chk({tag, " not busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        run = 1'b0;
        fill(8'h00);

        // Reset
        tick();
        tick();
        chk("rst state", 32'(state), 32'd0);
        chk("rst pc", 32'(pc), 32'd0);
        chk("rst addr", 32'(imem_addr), 32'd0);
        chk("rst acc", 32'(acc), 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst carry", 32'(carry), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst retire", 32'(retire), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle hold", 32'(state), 32'd0);

        // LDI 7, ADDI 12, HLT
        fill(8'hF0);
        rom[0] = 8'h17; rom[1] = 8'h4C; rom[2] = 8'hF0;
        start("p1");
        exec_one("ldi7");
        chk("ldi7 acc", 32'(acc), 32'd7);
        exec_one("addi12");
        chk("addi wrap acc", 32'(acc), 32'd3);
        chk("addi zero", 32'(zero), 32'd0);
        chk("addi carry", 32'(carry), 32'(CEN));
        exec_one("hlt");
        chk("hlt state", 32'(state), 32'd4);
        chk("hlt halted", 32'(halted), 32'd1);
        chk("hlt pc", 32'(pc), 32'd2);
        chk("hlt acc", 32'(acc), 32'd3);

        // LDI 9, STM 5, LDI 0, LDM 5; run held high while busy is ignored
        fill(8'hF0);
        rom[0] = 8'h19; rom[1] = 8'h35; rom[2] = 8'h10; rom[3] = 8'h25;
        start("p2");
        run = 1'b1;
        exec_one("ldi9");
        exec_one("stm5");
        run = 1'b0;
        exec_one("ldi0");
        chk("ldi0 acc", 32'(acc), 32'd0);
        chk("ldi0 zero", 32'(zero), 32'd1);
        exec_one("ldm5");
        chk("ldm5 acc", 32'(acc), 32'd9);
        chk("ldm5 zero", 32'(zero), 32'd0);
        chk("ldm5 pc", 32'(pc), 32'd4);
        run_to_halt("p2");

        // JZ taken
        fill(8'h00);
        rom[0] = 8'h10; rom[1] = 8'hC6; rom[6] = 8'hF0;
        start("br1");
        exec_one("br1 ldi0");
        exec_one("br1 jz");
        chk("jz taken pc", 32'(pc), 32'd6);
        chk("jz taken fetch", 32'(state), 32'd1);
        chk("jz taken addr", 32'(imem_addr), 32'd6);
        run_to_halt("br1");
        chk("br1 halt pc", 32'(pc), 32'd6);

        // JZ not taken
        fill(8'h00);
        rom[0] = 8'h11; rom[1] = 8'hC6; rom[2] = 8'hF0;
        start("br2");
        exec_one("br2 ldi1");
        exec_one("br2 jz");
        chk("jz fall pc", 32'(pc), 32'd2);
        chk("jz fall zero", 32'(zero), 32'd0);
        run_to_halt("br2");
        chk("br2 halt pc", 32'(pc), 32'd2);

        // PC wrap over 16 NOPs
        fill(8'h00);
        start("wrap");
        for (int i = 0; i < 15; i++) exec_one("nop");
        chk("pc 15", 32'(pc), 32'd15);
        exec_one("nop15");
        chk("pc wrap", 32'(pc), 32'd0);
        chk("wrap fetch", 32'(state), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrap rst", 32'(state), 32'd0);

        // ALU sweep with ram[1]=10
        fill(8'hF0);
        rom[0] = 8'h1A; rom[1] = 8'h31; rom[2] = 8'h1C; rom[3] = 8'h81;
        rom[4] = 8'hA1; rom[5] = 8'h91; rom[6] = 8'h63; rom[7] = 8'h71;
        rom[8] = 8'h51;
        start("alu");
        exec_one("alu ldi");
        exec_one("alu stm");
        exec_one("alu ldi12");
        chk("ldi12 acc", 32'(acc), 32'd12);
        exec_one("andm");
        chk("andm acc", 32'(acc), 32'd8);
        exec_one("xorm");
        chk("xorm acc", 32'(acc), 32'd2);
        exec_one("orm");
        chk("orm acc", 32'(acc), 32'd10);
        exec_one("subi");
        chk("subi acc", 32'(acc), 32'd7);
        chk("subi carry", 32'(carry), 32'(CEN));
        exec_one("subm");
        chk("subm acc", 32'(acc), 32'd13);
        chk("subm carry", 32'(carry), 32'd0);
        exec_one("addm");
        chk("addm acc", 32'(acc), 32'd7);
        run_to_halt("alu");

        // Reset during EXEC of STM 3 with acc=5 (ram[3] previously 2)
        fill(8'hF0);
        rom[0] = 8'h12; rom[1] = 8'h33; rom[2] = 8'h15; rom[3] = 8'h33;
        start("rstm");
        exec_one("rstm ldi2");
        exec_one("rstm stm");
        exec_one("rstm ldi5");
        chk("rstm acc5", 32'(acc), 32'd5);
        tick();
        tick();
        chk("rstm in exec", 32'(state), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm state", 32'(state), 32'd0);
        chk("rstm acc", 32'(acc), 32'd0);
        chk("rstm pc", 32'(pc), 32'd0);
        chk("rstm busy", 32'(busy), 32'd0);
        fill(8'hF0);
        rom[0] = 8'h23;
        start("rstm chk");
        exec_one("rstm ldm3");
        chk("ram3 kept", 32'(acc), 32'd2);
        run_to_halt("rstm chk");

        // Carry path: ram[0]=15, acc 15+1, JC 5, ADCM 0
        fill(8'hF0);
        rom[0] = 8'h1F; rom[1] = 8'h30; rom[2] = 8'h41; rom[3] = 8'hD5;
        rom[4] = 8'hE0; rom[5] = 8'hE0;
        start("cy");
        exec_one("cy ldi15");
        exec_one("cy stm0");
        exec_one("cy addi1");
        chk("addi1 acc", 32'(acc), 32'd0);
        chk("addi1 zero", 32'(zero), 32'd1);
        chk("addi1 carry", 32'(carry), 32'(CEN));
        exec_one("jc");
        chk("jc pc", 32'(pc), CEN ? 32'd5 : 32'd4);
        exec_one("adcm");
        chk("adcm acc", 32'(acc), 32'd0);
        chk("adcm carry", 32'(carry), 32'(CEN));
        chk("adcm pc", 32'(pc), CEN ? 32'd6 : 32'd5);
        chk("adcm zero", 32'(zero), 32'd1);
        run_to_halt("cy");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
